// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port, synchronous-read data memory between the CPU core
//   and a debug/loader port. At most one access is issued per cycle. A
//   requester that is not granted sees its own gnt low and must hold its
//   request and payload. The debug port may lock ownership for bursts. While
//   the CPU is waiting, the lock lasts at most MAX_LOCK consecutive debug
//   grants.
//
// Ports
//   clk, rst                  clock; synchronous active-low reset
//   cpu_req/we/addr/wdata     CPU request and payload (held until cpu_gnt)
//   cpu_gnt, cpu_stall        access issued this cycle / request waiting
//   cpu_rvalid, cpu_rdata     read return, one cycle after a granted read
//   dbg_req/we/addr/wdata     debug request and payload (held until dbg_gnt)
//   dbg_lock                  keep ownership across consecutive grants
//   dbg_gnt, dbg_rvalid/rdata as for the CPU
//   mem_we/addr/wdata         memory command for the granted side (0 if none)
//   mem_rdata                 memory read data, one cycle after the address
//   stall_cnt                 saturating count of cpu_stall cycles
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int MAX_LOCK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  input  logic          dbg_lock,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [15:0]   stall_cnt
);

  typedef enum logic {MODE_FREE, MODE_LOCK} mode_e;
  typedef enum logic {SIDE_CPU, SIDE_DBG} side_e;

  localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

  mode_e       mode_q, mode_d;
  side_e       last_q, last_d;
  logic [7:0]  lock_cnt_q, lock_cnt_d;
  logic        rv_cpu_q, rv_cpu_d;
  logic        rv_dbg_q, rv_dbg_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Debug keeps the memory only while it is already locked and still asks
  // for the lock. Otherwise the cycle is arbitrated round-robin.
  logic lock_hold;
  assign lock_hold = (mode_q == MODE_LOCK) && dbg_req && dbg_lock;

  // Grant decision: combinational from the current requests and the
  // registered state, so the access is issued in the request cycle.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (rst) begin
      if (lock_hold) begin
        // The CPU breaks the lock once the debug side has used its quota.
        if (cpu_req && (lock_cnt_q == MAX_LOCK_C)) cpu_gnt = 1'b1;
        else                                       dbg_gnt = 1'b1;
      end else if (cpu_req && dbg_req) begin
        // Tie: the side that did not win last time goes first.
        if (last_q == SIDE_DBG) cpu_gnt = 1'b1;
        else                    dbg_gnt = 1'b1;
      end else begin
        cpu_gnt = cpu_req;
        dbg_gnt = dbg_req;
      end
    end
  end

  // Memory command mux. An idle cycle drives all zeros.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  // Next-state logic
  always_comb begin
    mode_d     = mode_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;

    if (cpu_gnt)      last_d = SIDE_CPU;
    else if (dbg_gnt) last_d = SIDE_DBG;

    if (dbg_gnt && dbg_lock) begin
      mode_d = MODE_LOCK;
      if (mode_q == MODE_FREE) begin
        // The entry grant counts as the first locked grant.
        lock_cnt_d = 8'd1;
      end else if (lock_cnt_q != MAX_LOCK_C) begin
        lock_cnt_d = lock_cnt_q + 8'd1;
      end
    end else begin
      mode_d     = MODE_FREE;
      lock_cnt_d = 8'd0;
    end

    rv_cpu_d = cpu_gnt & ~cpu_we;
    rv_dbg_d = dbg_gnt & ~dbg_we;

    stall_cnt_d = stall_cnt_q;
    if (cpu_stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q      <= MODE_FREE;
      last_q      <= SIDE_DBG;
      lock_cnt_q  <= 8'd0;
      rv_cpu_q    <= 1'b0;
      rv_dbg_q    <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      mode_q      <= mode_d;
      last_q      <= last_d;
      lock_cnt_q  <= lock_cnt_d;
      rv_cpu_q    <= rv_cpu_d;
      rv_dbg_q    <= rv_dbg_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // A read return that is still pending when reset arrives is suppressed
  // immediately. It is not delivered in the reset cycle.
  assign cpu_rvalid = rv_cpu_q & rst;
  assign dbg_rvalid = rv_dbg_q & rst;
  assign cpu_rdata  = mem_rdata;
  assign dbg_rdata  = mem_rdata;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Scoreboarded bench for mem_arbiter. It includes a behavioural 256 x 16
//   synchronous-read memory. A second instance with MAX_LOCK = 255 is used
//   for the stall-counter saturation scenario.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
  logic [AW-1:0] cpu_addr, dbg_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata;
  logic          cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [DW-1:0] cpu_rdata, dbg_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [15:0]   stall_cnt;

  // Saturation instance
  logic          s_cpu_req, s_cpu_we, s_dbg_req, s_dbg_we, s_dbg_lock;
  logic [AW-1:0] s_cpu_addr, s_dbg_addr;
  logic [DW-1:0] s_cpu_wdata, s_dbg_wdata;
  logic          s_cpu_gnt, s_cpu_stall, s_cpu_rvalid, s_dbg_gnt, s_dbg_rvalid;
  logic [DW-1:0] s_cpu_rdata, s_dbg_rdata;
  logic          s_mem_we;
  logic [AW-1:0] s_mem_addr;
  logic [DW-1:0] s_mem_wdata;
  logic [DW-1:0] s_mem_rdata;
  logic [15:0]   s_stall_cnt;

  int checks = 0;
  int errors = 0;
  logic [15:0] cpu_q[$];
  logic [15:0] dbg_q[$];

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_cnt(stall_cnt)
  );

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(255)) dut_sat (
    .clk(clk), .rst(rst),
    .cpu_req(s_cpu_req), .cpu_we(s_cpu_we), .cpu_addr(s_cpu_addr), .cpu_wdata(s_cpu_wdata),
    .cpu_gnt(s_cpu_gnt), .cpu_stall(s_cpu_stall), .cpu_rvalid(s_cpu_rvalid), .cpu_rdata(s_cpu_rdata),
    .dbg_req(s_dbg_req), .dbg_we(s_dbg_we), .dbg_addr(s_dbg_addr), .dbg_wdata(s_dbg_wdata),
    .dbg_lock(s_dbg_lock), .dbg_gnt(s_dbg_gnt), .dbg_rvalid(s_dbg_rvalid), .dbg_rdata(s_dbg_rdata),
    .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_rdata(s_mem_rdata),
    .stall_cnt(s_stall_cnt)
  );

  assign s_mem_rdata = 16'h0000;

  // Behavioural memory. Address 0x10 is preloaded with 0x1234 during reset.
  logic [15:0] mem [0:255];
  always @(posedge clk) begin
    if (!rst) mem[8'h10] <= 16'h1234;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_lock = 0;
    s_cpu_req = 0; s_cpu_we = 0; s_cpu_addr = '0; s_cpu_wdata = '0;
    s_dbg_req = 0; s_dbg_we = 0; s_dbg_addr = '0; s_dbg_wdata = '0; s_dbg_lock = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 0;
    tick();
    tick();
    rst = 1;
    cpu_q.delete();
    dbg_q.delete();
  endtask

  task automatic test_reset();
    idle();
    rst = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h55; cpu_wdata = 16'hFFFF;
    dbg_req = 1; dbg_we = 1; dbg_addr = 8'h56; dbg_wdata = 16'hEEEE;
    @(negedge clk);
    checks++;
    if ({cpu_gnt, dbg_gnt, mem_we} !== 3'b000) begin
      errors++;
      $display("FAIL reset_forced_gnt: got gnt/gnt/we=%b required 000", {cpu_gnt, dbg_gnt, mem_we});
    end
    tick();
    tick();
    idle();
    @(negedge clk);
    checks++;
    if ({cpu_rvalid, dbg_rvalid, stall_cnt} !== {2'b00, 16'h0000}) begin
      errors++;
      $display("FAIL reset_state: got rv=%b%b stall=%h required rv=00 stall=0000", cpu_rvalid, dbg_rvalid, stall_cnt);
    end
    tick();
    rst = 1;
    $display("test_reset done");
  endtask

  task automatic test_cpu_read();
    logic [15:0] exp;
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
    @(negedge clk);
    checks++;
    if ({cpu_gnt, dbg_gnt, mem_we, mem_addr} !== {3'b100, 8'h10}) begin
      errors++;
      $display("FAIL cpu_read_gnt: got gnt=%b%b we=%b addr=%h required 10 0 10", cpu_gnt, dbg_gnt, mem_we, mem_addr);
    end
    if (cpu_gnt) cpu_q.push_back(16'h1234);
    tick();
    cpu_req = 0;
    checks++;
    if (!cpu_rvalid || dbg_rvalid || cpu_q.size() == 0) begin
      errors++;
      $display("FAIL cpu_read_rvalid: got cpu_rv=%b dbg_rv=%b required 1 0", cpu_rvalid, dbg_rvalid);
    end else begin
      exp = cpu_q.pop_front();
      if (cpu_rdata !== exp) begin
        errors++;
        $display("FAIL cpu_read_data: got %h required %h", cpu_rdata, exp);
      end
    end
    tick();
    checks++;
    if (cpu_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL cpu_read_rvalid_once: got %b required 0", cpu_rvalid);
    end
    $display("test_cpu_read done");
  endtask

  task automatic test_alternate();
    logic exp_c;
    logic [15:0] exp;
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
    dbg_req = 1; dbg_we = 1; dbg_addr = 8'h20; dbg_wdata = 16'hBEEF; dbg_lock = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_c = (i % 2 == 0);
      checks++;
      if ({cpu_gnt, dbg_gnt, cpu_stall} !== {exp_c, ~exp_c, ~exp_c}) begin
        errors++;
        $display("FAIL alt_cycle%0d: got cpu_gnt/dbg_gnt/stall=%b%b%b required %b%b%b",
                 i + 1, cpu_gnt, dbg_gnt, cpu_stall, exp_c, ~exp_c, ~exp_c);
      end
      if (cpu_gnt) cpu_q.push_back(16'h1234);
      tick();
      if (cpu_rvalid) begin
        checks++;
        exp = (cpu_q.size() != 0) ? cpu_q.pop_front() : 16'hxxxx;
        if (cpu_rdata !== exp) begin
          errors++;
          $display("FAIL alt_rdata: got %h required %h", cpu_rdata, exp);
        end
      end
      if (dbg_rvalid) begin
        checks++;
        errors++;
        $display("FAIL alt_dbg_rvalid: got 1 required 0 after write");
      end
    end
    idle();
    checks++;
    if (stall_cnt !== 16'd2 || cpu_q.size() != 0) begin
      errors++;
      $display("FAIL alt_stall_cnt: got stall=%0d pending=%0d required 2 0", stall_cnt, cpu_q.size());
    end
    // Read back the debug write.
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h20;
    @(negedge clk);
    if (cpu_gnt) cpu_q.push_back(16'hBEEF);
    tick();
    cpu_req = 0;
    checks++;
    if (!cpu_rvalid || cpu_q.size() == 0) begin
      errors++;
      $display("FAIL alt_readback: got rvalid=%b required 1", cpu_rvalid);
    end else begin
      exp = cpu_q.pop_front();
      if (cpu_rdata !== exp) begin
        errors++;
        $display("FAIL alt_readback_data: got %h required %h", cpu_rdata, exp);
      end
    end
    $display("test_alternate done");
  endtask

  task automatic test_lock_burst();
    int w;
    logic g_c, g_d, exp_c;
    logic [15:0] exp;
    idle();
    // A solo CPU write makes CPU the last winner, so debug takes the first tie.
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h30; cpu_wdata = 16'h5555;
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b1) begin
      errors++;
      $display("FAIL burst_pre_write: got cpu_gnt=%b required 1", cpu_gnt);
    end
    tick();
    cpu_we = 0;
    dbg_req = 1; dbg_we = 1; dbg_lock = 1;
    w = 0;
    for (int c = 0; c < 9; c++) begin
      dbg_addr = 8'(w);
      dbg_wdata = 16'hA000 + 16'(w);
      @(negedge clk);
      exp_c = (c == 4);
      g_c = cpu_gnt;
      g_d = dbg_gnt;
      checks++;
      if ({g_c, g_d} !== {exp_c, ~exp_c}) begin
        errors++;
        $display("FAIL burst_cycle%0d: got cpu_gnt/dbg_gnt=%b%b required %b%b", c + 1, g_c, g_d, exp_c, ~exp_c);
      end
      if (g_c) cpu_q.push_back(16'h5555);
      tick();
      if (g_c) cpu_req = 0;
      if (g_d) w++;
      if (w == 8) dbg_req = 0;
      if (cpu_rvalid) begin
        checks++;
        exp = (cpu_q.size() != 0) ? cpu_q.pop_front() : 16'hxxxx;
        if (cpu_rdata !== exp) begin
          errors++;
          $display("FAIL burst_cpu_rdata: got %h required %h", cpu_rdata, exp);
        end
      end
    end
    idle();
    checks++;
    if (w != 8 || cpu_q.size() != 0) begin
      errors++;
      $display("FAIL burst_complete: got words=%0d cpu_pending=%0d required 8 0", w, cpu_q.size());
    end
    for (int i = 0; i < 8; i++) begin
      dbg_req = 1; dbg_we = 0; dbg_addr = 8'(i);
      @(negedge clk);
      if (dbg_gnt) dbg_q.push_back(16'hA000 + 16'(i));
      tick();
      checks++;
      if (!dbg_rvalid || dbg_q.size() == 0) begin
        errors++;
        $display("FAIL burst_readback%0d: got rvalid=%b required 1", i, dbg_rvalid);
      end else begin
        exp = dbg_q.pop_front();
        if (dbg_rdata !== exp) begin
          errors++;
          $display("FAIL burst_readback%0d_data: got %h required %h", i, dbg_rdata, exp);
        end
      end
    end
    idle();
    $display("test_lock_burst done");
  endtask

  task automatic test_lock_drop();
    logic [3:0] exp_gnt [6];
    // {cpu_req, dbg_lock, expected cpu_gnt, expected dbg_gnt} per cycle
    exp_gnt[0] = 4'b0101;
    exp_gnt[1] = 4'b0101;
    exp_gnt[2] = 4'b0001;
    exp_gnt[3] = 4'b1110;
    exp_gnt[4] = 4'b0101;
    exp_gnt[5] = 4'b0001;
    idle();
    for (int c = 0; c < 6; c++) begin
      cpu_req = exp_gnt[c][3]; cpu_we = 1; cpu_addr = 8'h41; cpu_wdata = 16'h4141;
      dbg_req = 1; dbg_lock = exp_gnt[c][2]; dbg_we = 1;
      dbg_addr = 8'h40; dbg_wdata = 16'h4000 + 16'(c);
      @(negedge clk);
      checks++;
      if ({cpu_gnt, dbg_gnt} !== exp_gnt[c][1:0]) begin
        errors++;
        $display("FAIL lock_drop_cycle%0d: got cpu_gnt/dbg_gnt=%b%b required %b", c + 1, cpu_gnt, dbg_gnt, exp_gnt[c][1:0]);
      end
      tick();
    end
    idle();
    $display("test_lock_drop done");
  endtask

  task automatic test_reset_cancel();
    logic [15:0] exp;
    idle();
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h50; cpu_wdata = 16'h5050;
    @(negedge clk);
    tick();
    cpu_we = 0; cpu_addr = 8'h10;
    dbg_req = 1; dbg_we = 0; dbg_addr = 8'h10;
    @(negedge clk);
    checks++;
    if ({cpu_gnt, dbg_gnt, cpu_stall} !== 3'b011) begin
      errors++;
      $display("FAIL cancel_dbg_gnt: got cpu_gnt/dbg_gnt/stall=%b%b%b required 011", cpu_gnt, dbg_gnt, cpu_stall);
    end
    tick();
    rst = 0;
    @(negedge clk);
    checks++;
    if (dbg_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL cancel_rvalid_in_reset: got %b required 0", dbg_rvalid);
    end
    tick();
    checks++;
    if ({dbg_rvalid, cpu_rvalid, stall_cnt} !== {2'b00, 16'h0000}) begin
      errors++;
      $display("FAIL cancel_cleared: got rv=%b%b stall=%h required 00 0000", dbg_rvalid, cpu_rvalid, stall_cnt);
    end
    rst = 1;
    @(negedge clk);
    checks++;
    if ({cpu_gnt, dbg_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL cancel_tiebreak: got cpu_gnt/dbg_gnt=%b%b required 10", cpu_gnt, dbg_gnt);
    end
    if (cpu_gnt) cpu_q.push_back(16'h1234);
    tick();
    idle();
    checks++;
    if (!cpu_rvalid || dbg_rvalid || cpu_q.size() == 0) begin
      errors++;
      $display("FAIL cancel_cpu_read: got cpu_rv=%b dbg_rv=%b required 1 0", cpu_rvalid, dbg_rvalid);
    end else begin
      exp = cpu_q.pop_front();
      if (cpu_rdata !== exp) begin
        errors++;
        $display("FAIL cancel_cpu_rdata: got %h required %h", cpu_rdata, exp);
      end
    end
    $display("test_reset_cancel done");
  endtask

  task automatic test_saturation();
    int ngr;
    logic wrapped;
    logic [15:0] prev;
    do_reset();
    s_dbg_req = 1; s_dbg_lock = 1; s_dbg_we = 1; s_dbg_wdata = 16'h0F0F;
    @(negedge clk);
    checks++;
    if ({s_cpu_gnt, s_dbg_gnt} !== 2'b01) begin
      errors++;
      $display("FAIL sat_lock_entry: got cpu_gnt/dbg_gnt=%b%b required 01", s_cpu_gnt, s_dbg_gnt);
    end
    tick();
    s_cpu_req = 1;
    ngr = 0;
    wrapped = 0;
    prev = 16'h0000;
    // With a 255-grant lock the CPU wins on cycles k where k % 256 == 255,
    // so after k cycles the stall count is k - (k + 1) / 256.
    for (int k = 1; k <= 70000; k++) begin
      @(negedge clk);
      if (s_cpu_gnt) ngr++;
      tick();
      if (s_stall_cnt < prev) wrapped = 1;
      prev = s_stall_cnt;
      if (k == 1000 || k == 65791) begin
        checks++;
        if (s_stall_cnt !== 16'(k - (k + 1) / 256)) begin
          errors++;
          $display("FAIL sat_stall_at_%0d: got %h required %h", k, s_stall_cnt, 16'(k - (k + 1) / 256));
        end
      end
    end
    idle();
    checks++;
    if (s_stall_cnt !== 16'hFFFF || wrapped !== 1'b0) begin
      errors++;
      $display("FAIL sat_final: got stall=%h wrapped=%b required FFFF 0", s_stall_cnt, wrapped);
    end
    checks++;
    if (ngr != 70001 / 256) begin
      errors++;
      $display("FAIL sat_cpu_grants: got %0d required %0d", ngr, 70001 / 256);
    end
    $display("test_saturation done");
  endtask

  initial begin
    idle();
    rst = 0;
    test_reset();
    test_cpu_read();
    test_alternate();
    test_lock_burst();
    test_lock_drop();
    test_reset_cancel();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
